iter_counter: RTL and testbench

Parametrised, mode-selectable iteration counter with a start/busy/done handshake, the successor to the plain modulo counter used for sequencing. It counts up or down over a programmable period, either free-running with a wrap tick or as a one-shot that reports completion. It sits beside the iterative datapath, e.g. the CORDIC core, to step iterations and signal the final one. Mode and period are latched at start, so upstream can change them while a run is in progress.

---
 rtl/iter_counter_pkg.sv | 29 ++
 rtl/iter_counter.sv | 168 ++++++++++++++++
 tb/tb_iter_counter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/iter_counter_pkg.sv
// ---------------------------------------------------------------------------
// iter_counter_pkg
//
// Shared types and constants for the iteration counter.
//   iter_state_e      : FSM state encoding (IDLE, RUN, DONE).
//   MODE_ONESHOT_BIT  : mode bit selecting one-shot (1) or free-run wrap (0).
//   MODE_DOWN_BIT     : mode bit selecting down (1) or up (0) counting.
//   mode_is_oneshot / mode_is_down : decode helpers for a 2-bit mode word.
// ---------------------------------------------------------------------------
package iter_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } iter_state_e;

    localparam int MODE_ONESHOT_BIT = 0;
    localparam int MODE_DOWN_BIT    = 1;

    function automatic logic mode_is_oneshot(input logic [1:0] mode);
        return mode[MODE_ONESHOT_BIT];
    endfunction

    function automatic logic mode_is_down(input logic [1:0] mode);
        return mode[MODE_DOWN_BIT];
    endfunction

endpackage : iter_counter_pkg

// File: rtl/iter_counter.sv
// ---------------------------------------------------------------------------
// iter_counter
//
// Mode-selectable iteration counter with a start/busy/done handshake. Counts
// up or down over a programmable period N (max_i, 0 meaning 2^Width), either
// free-running with a wrap tick or as a one-shot that reports completion.
// Mode and period are captured when a start is accepted, so the requester may
// change them while a run is in progress.
//
// Ports:
//   clk_i    in   1      clock, rising edge
//   rst_i    in   1      asynchronous active-high reset
//   clr_i    in   1      synchronous clear: IDLE with count 0
//   start_i  in   1      start request, accepted in IDLE or DONE
//   stop_i   in   1      abort the current run (RUN only)
//   ena_i    in   1      count enable (RUN only)
//   mode_i   in   2      bit0 one-shot, bit1 down; latched at start
//   max_i    in   Width  period N, latched at start (0 = 2^Width)
//   cnt_o    out  Width  current count (registered)
//   tick_o   out  1      terminal-count step strobe (combinational)
//   busy_o   out  1      high while in RUN
//   done_o   out  1      one-cycle completion pulse (DONE state)
//
// Width must be at least 2.
// ---------------------------------------------------------------------------
module iter_counter
    import iter_counter_pkg::*;
#(
    parameter int Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             ena_i,
    input  logic [1:0]       mode_i,
    input  logic [Width-1:0] max_i,
    output logic [Width-1:0] cnt_o,
    output logic             tick_o,
    output logic             busy_o,
    output logic             done_o
);

    // -----------------------------------------------------------------------
    // State, count and latched configuration
    // -----------------------------------------------------------------------
    iter_state_e      state_q, state_d;
    logic [Width-1:0] cnt_q,   cnt_d;
    logic [1:0]       mode_q,  mode_d;
    logic [Width-1:0] max_q,   max_d;

    // -----------------------------------------------------------------------
    // Datapath: derived from the latched configuration for the current run
    // -----------------------------------------------------------------------
    logic             down_q;
    logic             oneshot_q;
    logic [Width-1:0] last_up;        // max-1, modulo 2^Width
    logic [Width-1:0] reload_val;     // start value of the running config
    logic [Width-1:0] new_start_val;  // start value of the incoming config
    logic [Width-1:0] step_val;       // count after one enabled step
    logic             at_terminal;
    logic             run_step;       // an enabled step actually happens

    assign down_q    = mode_is_down(mode_q);
    assign oneshot_q = mode_is_oneshot(mode_q);

    // max=0 gives last_up = all ones, which yields the full 2^Width period
    // without any special case.
    assign last_up       = max_q - Width'(1);
    assign reload_val    = down_q ? last_up : '0;
    assign new_start_val = mode_is_down(mode_i) ? (max_i - Width'(1)) : '0;
    assign step_val      = down_q ? (cnt_q - Width'(1)) : (cnt_q + Width'(1));
    assign at_terminal   = down_q ? (cnt_q == '0) : (cnt_q == last_up);

    // stop_i and clr_i both pre-empt a step, so neither may produce a tick.
    assign run_step = (state_q == RUN) && ena_i && !stop_i && !clr_i;

    // -----------------------------------------------------------------------
    // Next-state / next-count logic
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred; blocking assignments are correct
    // inside combinational processes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        max_d   = max_q;

        if (clr_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mode_d  = mode_i;
                        max_d   = max_i;
                        cnt_d   = new_start_val;
                        state_d = RUN;
                    end
                end

                RUN: begin
                    if (stop_i) begin
                        state_d = IDLE;
                    end else if (ena_i) begin
                        if (at_terminal) begin
                            if (oneshot_q) begin
                                // Count holds the terminal value into DONE.
                                state_d = DONE;
                            end else begin
                                cnt_d = reload_val;
                            end
                        end else begin
                            cnt_d = step_val;
                        end
                    end
                end

                DONE: begin
                    // A start here chains the next run with no IDLE gap.
                    if (start_i) begin
                        mode_d  = mode_i;
                        max_d   = max_i;
                        cnt_d   = new_start_val;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            max_q   <= max_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cnt_o  = cnt_q;
    assign tick_o = run_step && at_terminal;
    assign busy_o = (state_q == RUN);
    assign done_o = (state_q == DONE);

endmodule : iter_counter

// File: tb/tb_iter_counter.sv
// ---------------------------------------------------------------------------
// tb_iter_counter
//
// Self-checking bench for iter_counter (Width=4). Each stimulus cycle pushes
// the outputs expected for that cycle into a scoreboard queue; a monitor pops
// and compares them shortly after the falling edge, once the inputs for the
// coming rising edge have settled.
// ---------------------------------------------------------------------------
module tb_iter_counter;

    localparam int W = 4;

    logic         clk_i;
    logic         rst_i;
    logic         clr_i;
    logic         start_i;
    logic         stop_i;
    logic         ena_i;
    logic [1:0]   mode_i;
    logic [W-1:0] max_i;
    logic [W-1:0] cnt_o;
    logic         tick_o;
    logic         busy_o;
    logic         done_o;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] cnt;
        logic         tick;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t exp_q[$];

    iter_counter #(.Width(W)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (clr_i),
        .start_i (start_i),
        .stop_i  (stop_i),
        .ena_i   (ena_i),
        .mode_i  (mode_i),
        .max_i   (max_i),
        .cnt_o   (cnt_o),
        .tick_o  (tick_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs (held through the next rising edge) and
    // record the outputs expected during this cycle.
    task automatic cyc(input string tag,
                       input logic st, input logic sp, input logic en, input logic cl,
                       input logic [1:0] md, input logic [W-1:0] mx,
                       input logic [W-1:0] e_cnt, input logic e_tick,
                       input logic e_busy, input logic e_done);
        exp_t e;
        @(negedge clk_i);
        start_i = st;
        stop_i  = sp;
        ena_i   = en;
        clr_i   = cl;
        mode_i  = md;
        max_i   = mx;
        e.tag   = tag;
        e.cnt   = e_cnt;
        e.tick  = e_tick;
        e.busy  = e_busy;
        e.done  = e_done;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor.
    always begin
        @(negedge clk_i);
        #2;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, "/cnt"},  32'(cnt_o),  32'(e.cnt));
            check({e.tag, "/tick"}, 32'(tick_o), 32'(e.tick));
            check({e.tag, "/busy"}, 32'(busy_o), 32'(e.busy));
            check({e.tag, "/done"}, 32'(done_o), 32'(e.done));
        end
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        logic [W-1:0] c;

        rst_i   = 1'b1;
        clr_i   = 1'b0;
        start_i = 1'b0;
        stop_i  = 1'b0;
        ena_i   = 1'b0;
        mode_i  = 2'b00;
        max_i   = '0;

        #1;
        check("reset/cnt",  32'(cnt_o),  32'd0);
        check("reset/tick", 32'(tick_o), 32'd0);
        check("reset/busy", 32'(busy_o), 32'd0);
        check("reset/done", 32'(done_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        cyc("rst_idle", 0, 0, 0, 0, 2'b00, 4'd0, 4'd0, 0, 0, 0);

        // Up one-shot, N=5.
        cyc("os5_start", 1, 0, 1, 0, 2'b01, 4'd5, 4'd0, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            cyc($sformatf("os5_c%0d", i), 0, 0, 1, 0, 2'b01, 4'd5, 4'(i - 1), (i == 5), 1, 0);
        cyc("os5_done", 0, 0, 1, 0, 2'b01, 4'd5, 4'd4, 0, 0, 1);
        cyc("os5_idle", 0, 0, 1, 0, 2'b01, 4'd5, 4'd4, 0, 0, 0);

        // Down free-run, N=3, stopped at count 1.
        cyc("dfr_start", 1, 0, 1, 0, 2'b10, 4'd3, 4'd4, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            c = 4'(2 - ((i - 1) % 3));
            cyc($sformatf("dfr_c%0d", i), 0, (i == 8), 1, 0, 2'b10, 4'd3, c, (c == 0), 1, 0);
        end
        cyc("dfr_idle", 0, 0, 1, 0, 2'b10, 4'd3, 4'd1, 0, 0, 0);

        // Up free-run, max=0 -> period 16, two full wraps.
        cyc("ufr_start", 1, 0, 1, 0, 2'b00, 4'd0, 4'd1, 0, 0, 0);
        for (int i = 1; i <= 33; i++) begin
            c = 4'((i - 1) % 16);
            cyc($sformatf("ufr_c%0d", i), 0, (i == 33), 1, 0, 2'b00, 4'd0, c, (c == 15), 1, 0);
        end
        cyc("ufr_idle", 0, 0, 1, 0, 2'b00, 4'd0, 4'd0, 0, 0, 0);

        // Up one-shot N=4, ena toggling; mode/max changed and start pulsed mid-run.
        cyc("ena_start", 1, 0, 0, 0, 2'b01, 4'd4, 4'd0, 0, 0, 0);
        for (int i = 1; i <= 7; i++)
            cyc($sformatf("ena_c%0d", i), (i == 3 || i == 4), 0, i[0], 0,
                (i >= 2) ? 2'b10 : 2'b01, (i >= 2) ? 4'd9 : 4'd4,
                4'(i / 2), (i == 7), 1, 0);
        cyc("ena_done", 0, 0, 1, 0, 2'b10, 4'd9, 4'd3, 0, 0, 1);
        cyc("ena_idle", 0, 0, 1, 0, 2'b10, 4'd9, 4'd3, 0, 0, 0);

        // Back-to-back up one-shots, N=2, start held high.
        cyc("b2b_start", 1, 0, 1, 0, 2'b01, 4'd2, 4'd3, 0, 0, 0);
        for (int r = 0; r < 3; r++) begin
            cyc($sformatf("b2b_r%0d_c0", r), 1, 0, 1, 0, 2'b01, 4'd2, 4'd0, 0, 1, 0);
            cyc($sformatf("b2b_r%0d_c1", r), 1, 0, 1, 0, 2'b01, 4'd2, 4'd1, 1, 1, 0);
            cyc($sformatf("b2b_r%0d_dn", r), (r < 2), 0, 1, 0, 2'b01, 4'd2, 4'd1, 0, 0, 1);
        end
        cyc("b2b_idle", 0, 0, 1, 0, 2'b01, 4'd2, 4'd1, 0, 0, 0);

        // N=1 one-shot: ticks on the first enabled cycle.
        cyc("n1os_start", 1, 0, 1, 0, 2'b01, 4'd1, 4'd1, 0, 0, 0);
        cyc("n1os_c1",    0, 0, 1, 0, 2'b01, 4'd1, 4'd0, 1, 1, 0);
        cyc("n1os_done",  0, 0, 1, 0, 2'b01, 4'd1, 4'd0, 0, 0, 1);
        cyc("n1os_idle",  0, 0, 1, 0, 2'b01, 4'd1, 4'd0, 0, 0, 0);

        // N=1 down free-run: tick every cycle; stop at terminal suppresses it.
        cyc("n1fr_start", 1, 0, 1, 0, 2'b10, 4'd1, 4'd0, 0, 0, 0);
        for (int i = 1; i <= 4; i++)
            cyc($sformatf("n1fr_c%0d", i), 0, (i == 4), 1, 0, 2'b10, 4'd1, 4'd0, (i != 4), 1, 0);
        cyc("n1fr_idle", 0, 0, 1, 0, 2'b10, 4'd1, 4'd0, 0, 0, 0);

        // Down one-shot, max=0: starts at 15, ends at 0.
        cyc("d16_start", 1, 0, 1, 0, 2'b11, 4'd0, 4'd0, 0, 0, 0);
        for (int i = 1; i <= 16; i++)
            cyc($sformatf("d16_c%0d", i), 0, 0, 1, 0, 2'b11, 4'd0, 4'(16 - i), (i == 16), 1, 0);
        cyc("d16_done", 0, 0, 1, 0, 2'b11, 4'd0, 4'd0, 0, 0, 1);
        cyc("d16_idle", 0, 0, 1, 0, 2'b11, 4'd0, 4'd0, 0, 0, 0);

        // clr_i at the terminal count of a one-shot: no tick, no done.
        cyc("clr_start", 1, 0, 1, 0, 2'b01, 4'd3, 4'd0, 0, 0, 0);
        cyc("clr_c1",    0, 0, 1, 0, 2'b01, 4'd3, 4'd0, 0, 1, 0);
        cyc("clr_c2",    0, 0, 1, 0, 2'b01, 4'd3, 4'd1, 0, 1, 0);
        cyc("clr_c3",    0, 0, 1, 1, 2'b01, 4'd3, 4'd2, 0, 1, 0);
        cyc("clr_c4",    0, 0, 1, 0, 2'b01, 4'd3, 4'd0, 0, 0, 0);
        cyc("clr_c5",    0, 0, 1, 0, 2'b01, 4'd3, 4'd0, 0, 0, 0);

        // clr_i and start_i together in IDLE: clr wins.
        cyc("clrst_req",  1, 0, 1, 1, 2'b01, 4'd3, 4'd0, 0, 0, 0);
        cyc("clrst_idle", 0, 0, 1, 0, 2'b01, 4'd3, 4'd0, 0, 0, 0);

        // Asynchronous reset mid-run.
        cyc("arst_start", 1, 0, 1, 0, 2'b00, 4'd0, 4'd0, 0, 0, 0);
        for (int i = 1; i <= 4; i++)
            cyc($sformatf("arst_c%0d", i), 0, 0, 1, 0, 2'b00, 4'd0, 4'(i - 1), 0, 1, 0);
        #3;
        rst_i = 1'b1;
        #1;
        check("arst/cnt",  32'(cnt_o),  32'd0);
        check("arst/tick", 32'(tick_o), 32'd0);
        check("arst/busy", 32'(busy_o), 32'd0);
        check("arst/done", 32'(done_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        cyc("arst_after", 0, 0, 1, 0, 2'b00, 4'd0, 4'd0, 0, 0, 0);

        // Drain the scoreboard with a bounded wait.
        w = 0;
        #3;
        while (exp_q.size() > 0 && w < 5) begin
            @(negedge clk_i);
            #3;
            w++;
        end
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_iter_counter
